// File: rtl/uart_pkg.sv
// Shared types and constants for the serial transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        LINE_IDLE  = 1'b1;
  localparam logic        LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake and status between the byte source and uart_tx.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 send;
  logic                 ready;
  logic                 busy;
  logic                 done;

  modport master (
    output data,
    output send,
    input  ready,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  send,
    output ready,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: bit_end marks the last clock of a serial bit.
module uart_baud_gen import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end,
  output logic end_next
);

  localparam int unsigned     CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // wrap at the end of a bit, or snap back to zero on a state entry
  always_comb begin
    count_next = count + CW'(1);
    if (restart || bit_end) begin
      count_next = '0;
    end
  end

  assign bit_end  = (count == LAST);
  // lets the owner register outputs that depend on next cycle's bit_end
  assign end_next = (count_next == LAST);

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits,
// with a one-entry holding register for gapless back-to-back frames.
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx
);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] shifter_next;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] hold_next;
  logic                 hold_valid;
  logic                 hold_valid_next;
  logic [2:0]           bit_idx;
  logic [2:0]           bit_idx_next;
  logic                 stop_idx;
  logic                 stop_idx_next;

  logic tx_next;
  logic busy_q;
  logic busy_next;
  logic done_q;
  logic done_next;

  logic accept;
  logic frame_last;
  logic direct_load;
  logic restart;
  logic bit_end;
  logic end_next;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_end  (bit_end),
    .end_next (end_next)
  );

  assign accept      = bus.send && !hold_valid;
  assign frame_last  = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // an accepted byte bypasses the holding register when the shifter is free now
  assign direct_load = (state == IDLE) || frame_last;
  // counter is parked at zero while idle and restarted on every state entry
  assign restart     = (state == IDLE) || (state_next != state);

  assign bus.ready = !hold_valid;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // state, datapath and registered output update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      tx         <= LINE_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      shifter    <= shifter_next;
      hold       <= hold_next;
      hold_valid <= hold_valid_next;
      bit_idx    <= bit_idx_next;
      stop_idx   <= stop_idx_next;
      tx         <= tx_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
    end
  end

  // frame sequencing, shifter and holding register
  always_comb begin
    state_next      = state;
    shifter_next    = shifter;
    hold_next       = hold;
    hold_valid_next = hold_valid;
    bit_idx_next    = bit_idx;
    stop_idx_next   = stop_idx;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shifter_next = bus.data;
          state_next   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shifter_next = shifter >> 1;
          if (bit_idx == BIT_LAST) begin
            state_next    = STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx == STOP_LAST) begin
            if (hold_valid) begin
              shifter_next    = hold;
              hold_valid_next = 1'b0;
              state_next      = START;
            end else if (accept) begin
              shifter_next = bus.data;
              state_next   = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_idx_next = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (accept && !direct_load) begin
      hold_next       = bus.data;
      hold_valid_next = 1'b1;
    end
  end

  // outputs are computed from next-cycle values so tx/busy/done leave a flop
  always_comb begin
    tx_next   = LINE_IDLE;
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (stop_idx_next == STOP_LAST) && end_next;
    unique case (state_next)
      START:   tx_next = LINE_START;
      DATA:    tx_next = shifter_next[0];
      default: tx_next = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, hand-written corner sequences, and a
// random loopback run against a frame-level model and a behavioural receiver.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic tx1;
  logic tx4;

  uart_tx_if bus1 ();
  uart_tx_if bus4 ();

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1),
    .tx  (tx1)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4),
    .tx  (tx4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Line model for dut1: each queued element is one cycle of the line,
  // element 0 being the current cycle; empty queue means idle.
  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } elem_t;

  elem_t      line_q[$];
  logic       hold_full;
  logic [7:0] hold_byte;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];
  logic       obs_tx[$];
  logic       obs_done[$];
  bit         lb_on = 1'b0;

  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      elem_t e;
      e.busy = 1'b1;
      e.done = (i == 9);
      if (i == 0)      e.tx = 1'b0;
      else if (i <= 8) e.tx = b[i-1];
      else             e.tx = 1'b1;
      line_q.push_back(e);
    end
  endfunction

  task automatic cycle(input logic s, input logic [7:0] d, input string tag);
    bit    had_cur;
    bit    last;
    bit    accept;
    elem_t exp_e;
    bus1.send = s;
    bus1.data = d;
    had_cur = (line_q.size() > 0);
    last    = (line_q.size() == 1);
    accept  = s && !hold_full;
    if (hold_full && last) begin
      push_frame(hold_byte);
      hold_full = 1'b0;
    end else if (accept) begin
      if (!had_cur || last) begin
        push_frame(d);
      end else begin
        hold_full = 1'b1;
        hold_byte = d;
      end
    end
    if (accept && lb_on) sent_q.push_back(d);
    @(posedge clk);
    #1;
    if (had_cur) void'(line_q.pop_front());
    bus1.send = 1'b0;
    if (line_q.size() > 0) exp_e = line_q[0];
    else                   exp_e = 3'b100;
    check({tag, ".tx"},    tx1,        exp_e.tx);
    check({tag, ".busy"},  bus1.busy,  exp_e.busy);
    check({tag, ".done"},  bus1.done,  exp_e.done);
    check({tag, ".ready"}, bus1.ready, !hold_full);
    obs_tx.push_back(tx1);
    obs_done.push_back(bus1.done);
  endtask

  // behavioural one-sample-per-bit receiver on dut1's line
  int         rx_state = 0;
  logic [7:0] rx_byte  = '0;
  int         rx_err   = 0;
  always @(negedge clk) begin
    if (rst) begin
      rx_state = 0;
    end else if (lb_on) begin
      if (rx_state == 0) begin
        if (tx1 == 1'b0) rx_state = 1;
      end else if (rx_state <= 8) begin
        rx_byte = {tx1, rx_byte[7:1]};
        rx_state++;
      end else begin
        if (tx1) rx_q.push_back(rx_byte);
        else     rx_err++;
        rx_state = 0;
      end
    end
  end

  typedef struct {
    logic       send;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[12];
    logic       bb_exp[10];
    logic [7:0] b;
    int         n;

    bus1.send = 1'b0;
    bus1.data = '0;
    bus4.send = 1'b0;
    bus4.data = '0;
    hold_full = 1'b0;
    hold_byte = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.tx1",    tx1,        1'b1);
    check("reset.ready1", bus1.ready, 1'b1);
    check("reset.busy1",  bus1.busy,  1'b0);
    check("reset.done1",  bus1.done,  1'b0);
    check("reset.tx4",    tx4,        1'b1);
    check("reset.busy4",  bus4.busy,  1'b0);
    rst = 1'b0;
    repeat (2) cycle(1'b0, 8'h00, "idle");

    // single byte 0xA5; row k drives cycle k and expects cycle k+1
    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 12; k++) begin
      cycle(vt[k].send, vt[k].data, "single");
      check($sformatf("vec%0d.tx", k),    tx1,        vt[k].tx);
      check($sformatf("vec%0d.busy", k),  bus1.busy,  vt[k].busy);
      check($sformatf("vec%0d.done", k),  bus1.done,  vt[k].done);
      check($sformatf("vec%0d.ready", k), bus1.ready, vt[k].ready);
    end

    // reset asserted mid-frame while 0xFF is in the data bits
    cycle(1'b1, 8'hFF, "rstseq");
    repeat (4) cycle(1'b0, 8'h00, "rstseq");
    #2;
    rst = 1'b1;
    #1;
    check("midrst.tx",    tx1,        1'b1);
    check("midrst.ready", bus1.ready, 1'b1);
    check("midrst.busy",  bus1.busy,  1'b0);
    check("midrst.done",  bus1.done,  1'b0);
    line_q.delete();
    hold_full = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) cycle(1'b0, 8'h00, "postrst");

    // baud scaling on the 4-clock, 2-stop-bit instance
    bus4.data = 8'h01;
    bus4.send = 1'b1;
    @(posedge clk);
    #1;
    bus4.send = 1'b0;
    bus4.data = 8'hFE;
    for (int i = 1; i <= 47; i++) begin
      logic et;
      if (i <= 4)       et = 1'b0;
      else if (i <= 8)  et = 1'b1;
      else if (i <= 36) et = 1'b0;
      else              et = 1'b1;
      check($sformatf("baud.tx@%0d", i),   tx4,       et);
      check($sformatf("baud.busy@%0d", i), bus4.busy, (i <= 44));
      check($sformatf("baud.done@%0d", i), bus4.done, (i == 44));
      @(posedge clk);
      #1;
    end

    // back-to-back: second byte queued while first frame is on the line
    obs_tx.delete();
    obs_done.delete();
    cycle(1'b1, 8'h3C, "b2b");
    repeat (2) cycle(1'b0, 8'h00, "b2b");
    cycle(1'b1, 8'hC3, "b2b");
    repeat (18) cycle(1'b0, 8'h00, "b2b");
    bb_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 10; j++) begin
      check($sformatf("b2b.tx@%0d", 11 + j), obs_tx[10+j], bb_exp[j]);
    end
    check("b2b.done@10", obs_done[9],  1'b1);
    check("b2b.done@20", obs_done[19], 1'b1);

    // overrun: 0x55 offered while the holding register is full
    obs_tx.delete();
    obs_done.delete();
    cycle(1'b1, 8'h11, "ovr");
    cycle(1'b0, 8'h00, "ovr");
    cycle(1'b1, 8'h22, "ovr");
    cycle(1'b0, 8'h00, "ovr");
    cycle(1'b1, 8'h55, "ovr");
    repeat (20) cycle(1'b0, 8'h00, "ovr");
    for (int j = 0; j < 8; j++) b[j] = obs_tx[11+j];
    check("ovr.start", obs_tx[10], 1'b0);
    check("ovr.byte",  b,          8'h22);

    // accept in the last stop-bit cycle with the holding register empty
    obs_tx.delete();
    obs_done.delete();
    cycle(1'b1, 8'h00, "simul");
    repeat (9) cycle(1'b0, 8'h00, "simul");
    cycle(1'b1, 8'h81, "simul");
    repeat (12) cycle(1'b0, 8'h00, "simul");
    for (int j = 0; j < 8; j++) b[j] = obs_tx[11+j];
    check("simul.done@10", obs_done[9], 1'b1);
    check("simul.start",   obs_tx[10],  1'b0);
    check("simul.byte",    b,           8'h81);

    // random loopback into the behavioural receiver
    sent_q.delete();
    rx_q.delete();
    rx_err = 0;
    lb_on  = 1'b1;
    n = 0;
    while (sent_q.size() < 256 && n < 20000) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), "rand");
      n++;
    end
    while (line_q.size() > 0 && n < 20100) begin
      cycle(1'b0, 8'($urandom), "drain");
      n++;
    end
    repeat (2) cycle(1'b0, 8'h00, "drain");
    lb_on = 1'b0;
    check("lb.sent",      sent_q.size(), 256);
    check("lb.received",  rx_q.size(),   sent_q.size());
    check("lb.frame_err", rx_err,        0);
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("lb.byte%0d", i), rx_q[i], sent_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
